// File: rtl/level_select_pkg.sv
// level_select_pkg
// Shared constants and types for the level digit generator.
// Contents:
//   LEVEL_W / MAX_BCD_LEVEL  width and ceiling of the BCD level digit
//   HIT_W                    width of the hit counter
//   DEFAULT_*                default timing parameters (50 MHz clock)
//   level_step()             saturating +1/-1 level update helper
package level_select_pkg;

  localparam int LEVEL_W                 = 4;
  localparam int MAX_BCD_LEVEL           = 9;
  localparam int HIT_W                   = 8;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
  localparam int DEFAULT_HITS_PER_LEVEL  = 10;

  typedef logic [LEVEL_W-1:0] level_t;
  typedef logic [HIT_W-1:0]   hit_cnt_t;

  // Saturating step: inc and dec together cancel out, so the level is kept.
  function automatic level_t level_step(level_t cur, logic inc, logic dec, level_t max_lvl);
    level_t nxt;
    nxt = cur;
    if (inc && !dec) begin
      if (cur < max_lvl) begin
        nxt = cur + level_t'(1);
      end else begin
        nxt = cur;
      end
    end else if (dec && !inc) begin
      if (cur > level_t'(0)) begin
        nxt = cur - level_t'(1);
      end else begin
        nxt = cur;
      end
    end else begin
      nxt = cur;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/level_select_if.sv
// level_select_if
// Bundles the key/game inputs and the level outputs of level_select.
//   key_up_n, key_down_n  raw active-low pushbuttons (asynchronous)
//   game_active           1 = play mode, 0 = idle mode
//   hit                   single-cycle pulse per mole hit
//   level                 current BCD level 0..MAX_LEVEL
//   level_changed         one-cycle pulse when level takes a new value
//   hit_count             hits counted toward the next level
// modport slave is the level_select side, master is the driving side.
interface level_select_if;
  import level_select_pkg::*;

  logic     key_up_n;
  logic     key_down_n;
  logic     game_active;
  logic     hit;
  level_t   level;
  logic     level_changed;
  hit_cnt_t hit_count;

  modport master (
    output key_up_n, key_down_n, game_active, hit,
    input  level, level_changed, hit_count
  );

  modport slave (
    input  key_up_n, key_down_n, game_active, hit,
    output level, level_changed, hit_count
  );

endinterface

// File: rtl/level_select_key_debounce.sv
// key_debounce
// Synchronizes one raw active-low pushbutton, debounces it and emits a
// one-cycle press pulse on each accepted 1->0 transition.
//   clk     system clock
//   resetn  asynchronous active-low reset
//   key_n   raw pushbutton, active-low, asynchronous to clk
//   press   registered one-cycle press pulse
module key_debounce
  import level_select_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic resetn,
  input  logic key_n,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;

  // Debounce counter: runs only while the synced key disagrees with the accepted value.
  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    if (sync2_q != deb_q) begin
      if (cnt_q == CNT_LAST) begin
        deb_d = sync2_q;
        cnt_d = {CNT_W{1'b0}};
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = {CNT_W{1'b0}};
    end
    // Only the released->pressed edge is a press; releases produce nothing.
    press_d = deb_q & ~deb_d;
  end

  // Synchronizer, debounce state and press pulse registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      deb_q   <= 1'b1;
      cnt_q   <= {CNT_W{1'b0}};
      press_q <= 1'b0;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/level_select.sv
// level_select
// Produces the BCD game level for the seven-segment level digit.
// Idle: debounced up/down keys step the level with saturation.
// Play: every HITS_PER_LEVEL hits advance the level up to MAX_LEVEL.
//   clk     system clock
//   resetn  asynchronous active-low reset
//   bus     level_select_if.slave (keys, mode, hit in; level, pulse, count out)
module level_select
  import level_select_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int HITS_PER_LEVEL  = DEFAULT_HITS_PER_LEVEL,
  parameter int MAX_LEVEL       = MAX_BCD_LEVEL
) (
  input  logic                 clk,
  input  logic                 resetn,
  level_select_if.slave        bus
);

  localparam level_t   MAX_LVL  = level_t'(MAX_LEVEL);
  localparam hit_cnt_t HIT_LAST = hit_cnt_t'(HITS_PER_LEVEL - 1);

  logic     up_press_s, down_press_s;
  level_t   level_q, level_d;
  hit_cnt_t hit_count_q, hit_count_d;
  logic     level_changed_q, level_changed_d;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_up (
    .clk    (clk),
    .resetn (resetn),
    .key_n  (bus.key_up_n),
    .press  (up_press_s)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_down (
    .clk    (clk),
    .resetn (resetn),
    .key_n  (bus.key_down_n),
    .press  (down_press_s)
  );

  // Mode gating: keys drive the level when idle, hits drive it during play.
  always_comb begin
    level_d     = level_q;
    hit_count_d = hit_count_q;
    if (!bus.game_active) begin
      // Leaving play also lands here, which clears the hit count on the next edge.
      hit_count_d = {HIT_W{1'b0}};
      level_d     = level_step(level_q, up_press_s, down_press_s, MAX_LVL);
    end else if (bus.hit) begin
      if (hit_count_q == HIT_LAST) begin
        hit_count_d = {HIT_W{1'b0}};
        level_d     = level_step(level_q, 1'b1, 1'b0, MAX_LVL);
      end else begin
        hit_count_d = hit_count_q + hit_cnt_t'(1);
      end
    end else begin
      level_d = level_q;
    end
    // Saturated requests leave level_d equal to level_q, so no pulse is raised.
    level_changed_d = (level_d != level_q);
  end

  // Level, hit counter and change-pulse registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      level_q         <= level_t'(0);
      hit_count_q     <= {HIT_W{1'b0}};
      level_changed_q <= 1'b0;
    end else begin
      level_q         <= level_d;
      hit_count_q     <= hit_count_d;
      level_changed_q <= level_changed_d;
    end
  end

  assign bus.level         = level_q;
  assign bus.hit_count     = hit_count_q;
  assign bus.level_changed = level_changed_q;

endmodule

// File: tb/tb_level_select.sv
// tb_level_select
// Randomized and directed stimulus for level_select, checked every cycle
// against a behavioural model: key presses are derived from a sliding window
// of raw key samples, the level from clamped arithmetic and the hit counter
// from modular arithmetic.
module tb_level_select;
  import level_select_pkg::*;

  localparam int D    = 4;
  localparam int H    = 3;
  localparam int MAXL = 9;

  logic clk    = 1'b0;
  logic resetn = 1'b0;

  always #5 clk = ~clk;

  level_select_if bus();

  level_select #(
    .DEBOUNCE_CYCLES (D),
    .HITS_PER_LEVEL  (H),
    .MAX_LEVEL       (MAXL)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  // Reference model state
  int m_lvl, m_hc, m_lc;
  bit m_deb   [2];
  bit m_press [2];
  bit m_hist  [2][D+2];   // m_hist[k][0] = raw sample at the current edge, [i] = i edges earlier

  task automatic check_val(string tag, int obs, int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_lvl = 0;
    m_hc  = 0;
    m_lc  = 0;
    for (int k = 0; k < 2; k++) begin
      m_deb[k]   = 1'b1;
      m_press[k] = 1'b0;
      for (int i = 0; i < D + 2; i++) m_hist[k][i] = 1'b1;
    end
  endtask

  // One rising edge of the reference model.
  task automatic model_edge();
    int  prev, up, dn;
    bit  raw, flip;
    if (!resetn) begin
      model_reset();
      return;
    end
    up   = m_press[0];
    dn   = m_press[1];
    prev = m_lvl;
    if (!bus.game_active) begin
      m_hc  = 0;
      m_lvl = m_lvl + up - dn;
      if (m_lvl > MAXL) m_lvl = MAXL;
      if (m_lvl < 0)    m_lvl = 0;
    end else if (bus.hit) begin
      m_hc = (m_hc + 1) % H;
      if (m_hc == 0 && m_lvl < MAXL) m_lvl = m_lvl + 1;
    end
    m_lc = (m_lvl != prev) ? 1 : 0;
    // A key's accepted value flips once D consecutive synced samples
    // (raw samples from edges k-D-1 .. k-2) all disagree with it.
    for (int k = 0; k < 2; k++) begin
      raw = (k == 0) ? bus.key_up_n : bus.key_down_n;
      for (int i = D + 1; i > 0; i--) m_hist[k][i] = m_hist[k][i-1];
      m_hist[k][0] = raw;
      flip = 1'b1;
      for (int i = 2; i <= D + 1; i++) if (m_hist[k][i] == m_deb[k]) flip = 1'b0;
      m_press[k] = 1'b0;
      if (flip) begin
        m_deb[k]   = ~m_deb[k];
        m_press[k] = (m_deb[k] == 1'b0);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_val("level",         bus.level,         m_lvl);
    check_val("level_changed", bus.level_changed, m_lc);
    check_val("hit_count",     bus.hit_count,     m_hc);
    if (bus.level_changed) pulses++;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    model_reset();
    #1;
    check_val("rst_level",   bus.level,         0);
    check_val("rst_changed", bus.level_changed, 0);
    check_val("rst_hits",    bus.hit_count,     0);
    tick();
    tick();
    resetn = 1'b1;
  endtask

  task automatic press_keys(bit u, bit d);
    bus.key_up_n   = ~u;
    bus.key_down_n = ~d;
    repeat (D + 3) tick();
    bus.key_up_n   = 1'b1;
    bus.key_down_n = 1'b1;
    repeat (D + 3) tick();
  endtask

  task automatic hit_once();
    bus.hit = 1'b1;
    tick();
    bus.hit = 1'b0;
  endtask

  initial begin
    int up_hold, dn_hold;
    int exp_hc [3];
    bus.key_up_n    = 1'b1;
    bus.key_down_n  = 1'b1;
    bus.game_active = 1'b0;
    bus.hit         = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Held up key: level 0 -> 1 at edge 7, single pulse.
    bus.key_up_n = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (e == 6) check_val("tp1_pre_pulse", bus.level_changed, 0);
      if (e == 7) begin
        check_val("tp1_level",  bus.level,         1);
        check_val("tp1_pulse",  bus.level_changed, 1);
      end
      if (e == 8) check_val("tp1_post_pulse", bus.level_changed, 0);
    end
    bus.key_up_n = 1'b1;
    repeat (D + 3) tick();

    // Bouncing key shorter than the debounce window: no press.
    do_reset();
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      bus.key_up_n = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
      tick();
    end
    bus.key_up_n = 1'b1;
    repeat (10) tick();
    check_val("tp2_level",  bus.level, 0);
    check_val("tp2_pulses", pulses,    0);

    // Saturation at both ends and simultaneous presses.
    repeat (9) press_keys(1'b1, 1'b0);
    check_val("tp3_at_max", bus.level, 9);
    pulses = 0;
    press_keys(1'b1, 1'b0);
    check_val("tp3_sat_max",        bus.level, 9);
    check_val("tp3_sat_max_pulses", pulses,    0);
    repeat (4) press_keys(1'b0, 1'b1);
    check_val("tp3_mid", bus.level, 5);
    pulses = 0;
    press_keys(1'b1, 1'b1);
    check_val("tp3_both",        bus.level, 5);
    check_val("tp3_both_pulses", pulses,    0);
    repeat (5) press_keys(1'b0, 1'b1);
    pulses = 0;
    press_keys(1'b0, 1'b1);
    check_val("tp3_sat_min",        bus.level, 0);
    check_val("tp3_sat_min_pulses", pulses,    0);

    // Play mode from level 2: seven hits.
    repeat (2) press_keys(1'b1, 1'b0);
    bus.game_active = 1'b1;
    tick();
    for (int h = 1; h <= 7; h++) begin
      hit_once();
      tick();
      if (h == 3) check_val("tp4_after3", bus.level, 3);
      if (h == 6) check_val("tp4_after6", bus.level, 4);
    end
    check_val("tp4_hits_end", bus.hit_count, 1);
    pulses = 0;
    press_keys(1'b1, 1'b0);
    press_keys(1'b0, 1'b1);
    check_val("tp4_keys_ignored", bus.level, 4);
    check_val("tp4_keys_pulses",  pulses,    0);

    // Play at MAX_LEVEL: counter wraps, level holds; leaving play clears count.
    bus.game_active = 1'b0;
    tick();
    repeat (5) press_keys(1'b1, 1'b0);
    bus.game_active = 1'b1;
    tick();
    pulses = 0;
    exp_hc = '{1, 2, 0};
    for (int h = 0; h < 3; h++) begin
      hit_once();
      check_val("tp5_wrap_count", bus.hit_count, exp_hc[h]);
      tick();
    end
    check_val("tp5_level",  bus.level, 9);
    check_val("tp5_pulses", pulses,    0);
    hit_once();
    check_val("tp5_count_one", bus.hit_count, 1);
    bus.game_active = 1'b0;
    tick();
    check_val("tp5_idle_clear", bus.hit_count, 0);
    check_val("tp5_idle_level", bus.level,     9);

    // Reset mid-debounce with a partial hit count.
    bus.game_active = 1'b1;
    tick();
    hit_once();
    hit_once();
    check_val("tp6_count_two", bus.hit_count, 2);
    bus.key_up_n = 1'b0;
    repeat (3) tick();
    bus.key_up_n    = 1'b1;
    bus.game_active = 1'b0;
    do_reset();
    pulses = 0;
    repeat (12) tick();
    check_val("tp6_level",  bus.level, 0);
    check_val("tp6_pulses", pulses,    0);

    // Randomized phase.
    up_hold = 0;
    dn_hold = 0;
    for (int c = 0; c < 2000; c++) begin
      if (up_hold == 0) begin
        bus.key_up_n = 1'($urandom_range(0, 1));
        up_hold      = $urandom_range(1, 10);
      end
      if (dn_hold == 0) begin
        bus.key_down_n = 1'($urandom_range(0, 1));
        dn_hold        = $urandom_range(1, 10);
      end
      up_hold--;
      dn_hold--;
      if ($urandom_range(0, 79) == 0) bus.game_active = ~bus.game_active;
      bus.hit = ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0;
      if ($urandom_range(0, 999) == 0) begin
        do_reset();
      end else begin
        tick();
      end
    end
    bus.hit = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
